// File: rtl/vga_image_engine.sv
// vga_image_engine: VGA scanout of a scaled, positioned window into FRAMES stored images.
// Defining VGA_TEST_PATTERN_EN adds input test_mode, which swaps window pixels for colour bars.
module vga_image_engine #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int DIV = 4,
  parameter int ROM_LAT = 1,
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int SCALE_SH = 1,
  parameter int X_OFF = 0,
  parameter int Y_OFF = 0,
  parameter int FRAMES = 4,
  parameter int ADDR_W = 19,
  parameter logic [11:0] BG_COLOR = 12'h000,
  localparam int FSW = FRAMES > 1 ? $clog2(FRAMES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FSW-1:0]    frame_sel,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [11:0]       mem_data,
  output logic [11:0]       D_out,
  output logic              hs,
  output logic              vs,
  output logic              frame_done
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int X_END = X_OFF + (IMG_W << SCALE_SH);
  localparam int Y_END = Y_OFF + (IMG_H << SCALE_SH);
  localparam int FRAME_SZ = IMG_W * IMG_H;
  localparam int DW = $clog2(DIV);
  localparam int SW = SCALE_SH + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'((1 << SCALE_SH) - 1);
  localparam logic [15:0] H_LAST = 16'(H_TOT - 1), V_LAST = 16'(V_TOT - 1);
  localparam logic [15:0] H_ACT = 16'(H_ACTIVE), V_ACT = 16'(V_ACTIVE);
  localparam logic [15:0] H_S0 = 16'(H_ACTIVE + H_FP), H_S1 = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] V_S0 = 16'(V_ACTIVE + V_FP), V_S1 = 16'(V_ACTIVE + V_FP + V_SYNC);
  // Window edges are clipped to the active area so the image never spills into blanking.
  localparam logic [15:0] X_LO = 16'(X_OFF), X_HI = 16'(X_END < H_ACTIVE ? X_END : H_ACTIVE);
  localparam logic [15:0] Y_LO = 16'(Y_OFF), Y_HI = 16'(Y_END < V_ACTIVE ? Y_END : V_ACTIVE);

  if (DIV < 2 || ROM_LAT >= DIV) begin : g_bad_cfg
    $error("vga_image_engine: need DIV >= 2 and ROM_LAT < DIV");
  end

  logic [DW-1:0]     div;
  logic [15:0]       hcnt, vcnt, ix;
  logic [SW-1:0]     sub;
  logic [ADDR_W-1:0] frame_base, line_base, addr;
  logic              pix_ce, eol, de, row_in, win, rd_en;
  logic              s1_win, s1_de, s1_hs, s1_vs;
  logic [11:0]       win_rgb;

  always_comb begin
    pix_ce = div == DIV_LAST;
    eol = hcnt == H_LAST;
    de = hcnt < H_ACT && vcnt < V_ACT;
    row_in = vcnt >= Y_LO && vcnt < Y_HI;
    win = row_in && hcnt >= X_LO && hcnt < X_HI;
    ix = (hcnt - X_LO) >> SCALE_SH;
    addr = frame_base + line_base + ADDR_W'(ix);
    frame_done = pix_ce && hcnt == '0 && vcnt == V_ACT;
  end

`ifdef VGA_TEST_PATTERN_EN
  logic       s1_tp;
  logic [2:0] s1_bar;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_tp <= 1'b0;
      s1_bar <= '0;
    end else if (pix_ce) begin
      s1_tp <= test_mode;
      s1_bar <= hcnt[9:7];
    end
  end
  always_comb begin
    rd_en = win && !test_mode;
    win_rgb = s1_tp ? {{4{s1_bar[0]}}, {4{s1_bar[1]}}, {4{s1_bar[2]}}} : mem_data;
  end
`else
  always_comb begin
    rd_en = win;
    win_rgb = mem_data;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
      hcnt <= '0;
      vcnt <= '0;
      sub <= '0;
      line_base <= '0;
      frame_base <= '0;
      mem_addr <= '0;
      mem_en <= 1'b0;
      s1_win <= 1'b0;
      s1_de <= 1'b0;
      s1_hs <= 1'b1;
      s1_vs <= 1'b1;
      D_out <= '0;
      hs <= 1'b1;
      vs <= 1'b1;
    end else begin
      div <= pix_ce ? '0 : div + 1'b1;
      if (pix_ce) begin
        hcnt <= eol ? '0 : hcnt + 1'b1;
        if (eol && vcnt == V_LAST) begin
          vcnt <= '0;
          sub <= '0;
          line_base <= '0;
        end else if (eol) begin
          vcnt <= vcnt + 1'b1;
          // Image row advances once every 2^SCALE_SH window lines.
          if (row_in) begin
            sub <= sub == SUB_LAST ? '0 : sub + 1'b1;
            if (sub == SUB_LAST) line_base <= line_base + ADDR_W'(IMG_W);
          end
        end
        if (frame_done && 32'(frame_sel) < 32'(FRAMES))
          frame_base <= ADDR_W'(32'(frame_sel) * 32'(FRAME_SZ));
        mem_addr <= win ? addr : '0;
        mem_en <= rd_en;
        s1_win <= win;
        s1_de <= de;
        s1_hs <= !(hcnt >= H_S0 && hcnt < H_S1);
        s1_vs <= !(vcnt >= V_S0 && vcnt < V_S1);
        D_out <= s1_win ? win_rgb : (s1_de ? BG_COLOR : 12'h000);
        hs <= s1_hs;
        vs <= s1_vs;
      end
    end
  end
endmodule
